// File: rtl/fetch_buffer_if.sv
// Handshake bundle for fetch_buffer: instruction-memory request/response,
// EX redirect and the valid/ready link into the IF/ID register.
interface fetch_buffer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_inst,
    input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_inst,
    output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: sequential word fetches, PC-tagged FIFO, redirect flush.
// Optional FETCH_BYPASS_EN presents a response straight to IF/ID when the FIFO is empty.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic            clk,
  input logic            reset,
  fetch_buffer_if.master bus
);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] fl_rd_ptr_reg, fl_rd_ptr_next;
  logic [AW-1:0] fl_wr_ptr_reg, fl_wr_ptr_next;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] inst_mem  [DEPTH];
  logic [31:0] fl_pc_mem [DEPTH];

  logic [CW:0] credit_used;
  logic        req, accept, resp, keep, bypass, push, pop, valid;
  logic [31:0] resp_pc, redirect_target;

  // Credit counts both queued and in-flight fetches, so the FIFO can never overflow.
  assign credit_used     = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign req             = !reset && !bus.redirect_valid && (credit_used < DEPTH_W);
  assign accept          = req && bus.imem_ready;
  assign resp            = bus.imem_rvalid;
  assign resp_pc         = fl_pc_mem[fl_rd_ptr_reg];
  assign keep            = !reset && resp && !bus.redirect_valid && (discard_reg == '0);
  assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_BYPASS_EN
  assign bypass = keep && (count_reg == '0);
`else
  assign bypass = 1'b0;
`endif

  assign valid = !reset && ((count_reg != '0) || bypass);
  assign pop   = !reset && (count_reg != '0) && bus.if_ready;
  assign push  = keep && !(bypass && bus.if_ready);

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_reg;

  always_comb begin
    bus.if_valid = valid;
    bus.if_pc    = 32'h0;
    bus.if_inst  = NOP;
    if (valid && (count_reg != '0)) begin
      bus.if_pc   = pc_mem[rd_ptr_reg];
      bus.if_inst = inst_mem[rd_ptr_reg];
    end
`ifdef FETCH_BYPASS_EN
    else if (valid) begin
      bus.if_pc   = resp_pc;
      bus.if_inst = bus.imem_rdata;
    end
`endif
  end

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    count_next       = count_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;
    discard_next     = discard_reg;
    outstanding_next = outstanding_reg + CW'(accept) - CW'(resp);
    fl_wr_ptr_next   = fl_wr_ptr_reg + AW'(accept);
    fl_rd_ptr_next   = fl_rd_ptr_reg + AW'(resp);
    if (bus.redirect_valid) begin
      // Every request still in flight after this cycle belongs to the old path.
      fetch_pc_next = redirect_target;
      count_next    = '0;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      discard_next  = outstanding_reg - CW'(resp);
    end else begin
      if (accept) fetch_pc_next = fetch_pc_reg + 32'd4;
      if (resp && (discard_reg != '0)) discard_next = discard_reg - CW'(1);
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop) rd_ptr_next = rd_ptr_reg + AW'(1);
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      fl_rd_ptr_reg   <= '0;
      fl_wr_ptr_reg   <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
      fl_rd_ptr_reg   <= fl_rd_ptr_next;
      fl_wr_ptr_reg   <= fl_wr_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= resp_pc;
      inst_mem[wr_ptr_reg] <= bus.imem_rdata;
    end
    if (accept) fl_pc_mem[fl_wr_ptr_reg] <= fetch_pc_reg;
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: memory model with random latency/backpressure and a
// queue-based reference model of the fetch front end.
module tb_fetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct { logic [31:0] pc; logic drop; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_buffer_if bus();
  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.clk(clk), .reset(reset), .bus(bus));

  fl_t   fl_q[$];
  ent_t  out_q[$];
  mreq_t mem_q[$];
  logic [31:0] m_pc;
  int cyc, checks, errors;
  int lat_min, lat_max;
  bit found;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic bit resp_due();
    return mem_q.size() > 0 && mem_q[0].due <= cyc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic rst, input logic redir, input logic [31:0] rpc,
                      input logic ifr, input logic mr);
    logic rv, byp, usable, exp_req, exp_val, s_req;
    logic [31:0] rd, exp_pc, exp_inst, s_addr;
    fl_t head;
    mreq_t m;
    reset = rst;
    bus.redirect_valid = redir;
    bus.redirect_pc = rpc;
    bus.if_ready = ifr;
    bus.imem_ready = mr;
    rv = !rst && resp_due();
    rd = rv ? mem_word(mem_q[0].addr) : $urandom;
    bus.imem_rvalid = rv;
    bus.imem_rdata = rd;
    #3;
    if (rv) begin
      checks++;
      assert (fl_q.size() > 0) else begin
        errors++;
        $error("FAIL rvalid_without_outstanding observed=%0d expected=>0 cycle=%0d", fl_q.size(), cyc);
      end
    end
    head = (rv && fl_q.size() > 0) ? fl_q[0] : '{32'h0, 1'b1};
    usable = rv && !head.drop && !redir;
    exp_req = !rst && !redir && (out_q.size() + fl_q.size() < DEPTH);
    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = usable && out_q.size() == 0;
`endif
    exp_val = !rst && (out_q.size() != 0 || byp);
    exp_pc = 32'h0;
    exp_inst = 32'h0000_0013;
    if (exp_val && out_q.size() != 0) begin
      exp_pc = out_q[0].pc;
      exp_inst = out_q[0].inst;
    end else if (exp_val) begin
      exp_pc = head.pc;
      exp_inst = rd;
    end
    chk("imem_req", {31'h0, bus.imem_req}, {31'h0, exp_req});
    if (!rst) chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_valid", {31'h0, bus.if_valid}, {31'h0, exp_val});
    chk("if_pc", bus.if_pc, exp_pc);
    chk("if_inst", bus.if_inst, exp_inst);
    s_req = bus.imem_req;
    s_addr = bus.imem_addr;

    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      fl_q.delete();
      out_q.delete();
      mem_q.delete();
      m_pc = RESET_PC;
    end else begin
      if (rv) begin
        void'(mem_q.pop_front());
        if (fl_q.size() > 0) void'(fl_q.pop_front());
      end
      if (out_q.size() != 0 && ifr) void'(out_q.pop_front());
      if (redir) begin
        out_q.delete();
        for (int i = 0; i < fl_q.size(); i++) begin
          fl_t t;
          t = fl_q[i];
          t.drop = 1'b1;
          fl_q[i] = t;
        end
        m_pc = rpc & 32'hFFFF_FFFC;
      end else begin
        if (usable && !(byp && ifr)) out_q.push_back('{head.pc, rd});
        if (exp_req && mr) begin
          fl_q.push_back('{m_pc, 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
      if (s_req && mr) begin
        m.addr = s_addr;
        m.due = cyc + $urandom_range(lat_max, lat_min) - 1;
        if (mem_q.size() > 0 && m.due <= mem_q[mem_q.size()-1].due)
          m.due = mem_q[mem_q.size()-1].due + 1;
        mem_q.push_back(m);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; m_pc = RESET_PC;
    lat_min = 1; lat_max = 1;
    reset = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.if_ready = 1'b1;
    bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;

    repeat (3) step(1, 0, 0, 1, 1);
    // Streaming with single-cycle memory
    repeat (20) step(0, 0, 0, 1, 1);
    // IF/ID stalled, then released
    repeat (10) step(0, 0, 0, 0, 1);
    repeat (10) step(0, 0, 0, 1, 1);
    // Memory backpressure
    repeat (3) step(0, 0, 0, 1, 0);
    repeat (6) step(0, 0, 0, 1, 1);
    // Redirect with two requests outstanding
    lat_min = 3; lat_max = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (fl_q.size() == 2) found = 1;
      else step(0, 0, 0, 1, 1);
    end
    chk("two_outstanding_reached", {31'h0, found}, 32'h1);
    step(0, 1, 32'h8000_0102, 1, 1);
    repeat (15) step(0, 0, 0, 1, 1);
    // Redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    repeat (6) step(0, 0, 0, 1, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (resp_due() && out_q.size() > 0) found = 1;
      else step(0, 0, 0, 1, 1);
    end
    chk("resp_pop_redirect_reached", {31'h0, found}, 32'h1);
    step(0, 1, 32'h8000_0200, 1, 1);
    chk("flushed_if_valid", {31'h0, bus.if_valid}, 32'h0);
    repeat (8) step(0, 0, 0, 1, 1);
    // Address wrap-around
    step(0, 1, 32'hFFFF_FFFC, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("wrap_addr", bus.imem_addr, 32'h0000_0004);
    repeat (6) step(0, 0, 0, 1, 1);
    // Reset mid-stream
    step(1, 0, 0, 1, 1);
    chk("reset_if_valid", {31'h0, bus.if_valid}, 32'h0);
    repeat (10) step(0, 0, 0, 1, 1);
    // Randomized traffic
    lat_min = 1; lat_max = 5;
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 5, $urandom,
           $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
